// File: rtl/cache.sv
// Direct-mapped, write-back, write-allocate cache with 4-word lines and a block-wide memory port.
// Optional hit/miss performance counters are built only when CACHE_PERF_CNT_EN is defined.
module cache #(
    parameter int INDEX_W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic         proc_stall,
    output logic [31:0]  proc_rdata,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic         mem_ready,
    input  logic [127:0] mem_rdata,
    output logic [31:0]  hit_cnt,
    output logic [31:0]  miss_cnt
);

    // state      | meaning
    // S_IDLE     | serve hits; on a miss launch writeback or refill
    // S_WRITEBACK| dirty victim line being written to memory
    // S_ALLOCATE | requested line being read from memory
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2
    } state_t;

    localparam int TAG_W = 28 - INDEX_W;
    localparam int LINES = 1 << INDEX_W;

    state_t             state_q;
    logic               valid_q [LINES];
    logic               dirty_q [LINES];
    logic [TAG_W-1:0]   tag_q   [LINES];
    logic [127:0]       data_q  [LINES];

    logic [INDEX_W-1:0] miss_idx_q;
    logic [TAG_W-1:0]   miss_tag_q;
    logic               mem_read_q;
    logic               mem_write_q;
    logic [27:0]        mem_addr_q;
    logic [127:0]       mem_wdata_q;

    logic [1:0]         req_off;
    logic [INDEX_W-1:0] req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic               request;
    logic               hit;
    logic               miss;
    logic [127:0]       merged_line;

    assign req_off = proc_addr[1:0];
    assign req_idx = proc_addr[INDEX_W+1:2];
    assign req_tag = proc_addr[29:INDEX_W+2];
    assign request = proc_read | proc_write;

    assign hit  = (state_q == S_IDLE) & request & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
    assign miss = (state_q == S_IDLE) & request & ~hit;

    assign proc_stall = request & ~hit;
    assign proc_rdata = data_q[req_idx][{req_off, 5'd0} +: 32];

    always_comb begin
        merged_line = data_q[req_idx];
        merged_line[{req_off, 5'd0} +: 32] = proc_wdata;
    end

    // Miss index/tag are latched so a request dropped mid-miss cannot disturb the transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            miss_idx_q  <= '0;
            miss_tag_q  <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            for (int i = 0; i < LINES; i++) begin
                valid_q[i] <= 1'b0;
                dirty_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (hit && proc_write) begin
                        data_q[req_idx]  <= merged_line;
                        dirty_q[req_idx] <= 1'b1;
                    end else if (miss) begin
                        miss_idx_q <= req_idx;
                        miss_tag_q <= req_tag;
                        if (valid_q[req_idx] && dirty_q[req_idx]) begin
                            state_q     <= S_WRITEBACK;
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= {tag_q[req_idx], req_idx};
                            mem_wdata_q <= data_q[req_idx];
                        end else begin
                            state_q    <= S_ALLOCATE;
                            mem_read_q <= 1'b1;
                            mem_addr_q <= {req_tag, req_idx};
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (mem_ready) begin
                        state_q     <= S_ALLOCATE;
                        mem_write_q <= 1'b0;
                        mem_wdata_q <= '0;
                        mem_read_q  <= 1'b1;
                        mem_addr_q  <= {miss_tag_q, miss_idx_q};
                    end
                end
                S_ALLOCATE: begin
                    if (mem_ready) begin
                        state_q             <= S_IDLE;
                        mem_read_q          <= 1'b0;
                        mem_addr_q          <= '0;
                        data_q[miss_idx_q]  <= mem_rdata;
                        valid_q[miss_idx_q] <= 1'b1;
                        dirty_q[miss_idx_q] <= 1'b0;
                        tag_q[miss_idx_q]   <= miss_tag_q;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef CACHE_PERF_CNT_EN
    logic        refilled_q;
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // The completing cycle after a refill is part of the miss, not a separate hit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refilled_q <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            refilled_q <= (state_q == S_ALLOCATE) && mem_ready;
            if (hit && !refilled_q) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign hit_cnt  = 32'd0;
    assign miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_cache.sv
// Self-checking bench for cache: flat word-memory reference, per-index tag model and a
// latency-programmable block memory responder.
module tb_cache;

    localparam int INDEX_W = 3;

    logic         clk;
    logic         rst_n;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ready = 1'b0;
    logic [127:0] mem_rdata = '0;
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;

    cache #(.INDEX_W(INDEX_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .proc_rdata (proc_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int lat   = 2;
    logic spurious = 1'b0;

    logic [127:0] backing [logic [27:0]];
    logic [31:0]  ref_w   [logic [29:0]];
    logic [27:0]  rd_q[$];
    logic [27:0]  wb_addr_q[$];
    logic [127:0] wb_data_q[$];

    logic         m_valid [8];
    logic         m_dirty [8];
    logic [24:0]  m_tag   [8];
    int           exp_hits = 0;
    int           exp_miss = 0;

    function automatic logic [31:0] init_word(input logic [29:0] a);
        logic [31:0] x;
        x = {2'b00, a} * 32'h9E37_79B1 + 32'h7F4A_7C15;
        return x ^ {x[15:0], x[31:16]};
    endfunction

    function automatic logic [127:0] bk_read(input logic [27:0] b);
        logic [127:0] r;
        if (backing.exists(b)) return backing[b];
        for (int w = 0; w < 4; w++) begin
            logic [1:0] wo;
            wo = w[1:0];
            r[w*32 +: 32] = init_word({b, wo});
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_read(input logic [29:0] a);
        if (ref_w.exists(a)) return ref_w[a];
        return init_word(a);
    endfunction

    function automatic logic [127:0] ref_block(input logic [27:0] b);
        logic [127:0] r;
        for (int w = 0; w < 4; w++) begin
            logic [1:0] wo;
            wo = w[1:0];
            r[w*32 +: 32] = ref_read({b, wo});
        end
        return r;
    endfunction

    // Block memory: answers each request after `lat` cycles with a one-cycle ready pulse.
    int          resp_cnt = 0;
    logic [27:0] resp_addr;
    always @(negedge clk) begin
        if (spurious) begin
            mem_ready = 1'b1;
            mem_rdata = {4{32'hBADC_0DE5}};
            spurious  = 1'b0;
        end else if (mem_read || mem_write) begin
            if (resp_cnt == 0) begin
                resp_addr = mem_addr;
            end else begin
                total++;
                if (mem_addr !== resp_addr) begin
                    bad++;
                    $display("FAIL mem_addr_stable got=%h exp=%h", mem_addr, resp_addr);
                end
            end
            resp_cnt++;
            if (resp_cnt >= lat) begin
                mem_ready = 1'b1;
                if (mem_write) begin
                    backing[mem_addr] = mem_wdata;
                    wb_addr_q.push_back(mem_addr);
                    wb_data_q.push_back(mem_wdata);
                end else begin
                    mem_rdata = bk_read(mem_addr);
                    rd_q.push_back(mem_addr);
                end
                resp_cnt = 0;
            end else begin
                mem_ready = 1'b0;
            end
        end else begin
            mem_ready = 1'b0;
            resp_cnt  = 0;
        end
    end

    // Called at a negedge; returns at the negedge after the request completes.
    task automatic access(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] wd);
        logic [2:0]   idx;
        logic [24:0]  tg;
        logic         is_hit;
        logic         do_wb;
        logic [27:0]  victim;
        logic [127:0] exp_blk;
        logic [31:0]  got;
        logic [31:0]  exp_rd;
        logic         done;
        int           exp_stall;
        int           stalls;
        int           wb0;
        int           rd0;
        idx       = a[4:2];
        tg        = a[29:5];
        is_hit    = m_valid[idx] && (m_tag[idx] == tg);
        do_wb     = !is_hit && m_valid[idx] && m_dirty[idx];
        victim    = {m_tag[idx], idx};
        exp_blk   = ref_block(victim);
        exp_rd    = ref_read(a);
        exp_stall = is_hit ? 0 : (do_wb ? 1 + 2 * lat : 1 + lat);
        wb0       = wb_addr_q.size();
        rd0       = rd_q.size();

        proc_read  = rd;
        proc_write = wr;
        proc_addr  = a;
        proc_wdata = wd;
        stalls = 0;
        done   = 1'b0;
        while (!done) begin
            #1;
            if (!proc_stall) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (stalls > 200) begin
                    total++;
                    bad++;
                    $display("FAIL access_timeout addr=%h stalled=%0d cycles", a, stalls);
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        got = proc_rdata;
        @(negedge clk);
        proc_read  = 1'b0;
        proc_write = 1'b0;

        total++;
        if (stalls !== exp_stall) begin
            bad++;
            $display("FAIL stall_cycles addr=%h got=%0d exp=%0d", a, stalls, exp_stall);
        end
        if (rd && !wr) begin
            total++;
            if (got !== exp_rd) begin
                bad++;
                $display("FAIL read_data addr=%h got=%h exp=%h", a, got, exp_rd);
            end
        end
        total++;
        if (wb_addr_q.size() != wb0 + (do_wb ? 1 : 0)) begin
            bad++;
            $display("FAIL writeback_count addr=%h got=%0d exp=%0d", a, wb_addr_q.size() - wb0, do_wb ? 1 : 0);
        end else if (do_wb) begin
            total++;
            if (wb_addr_q[$] !== victim) begin
                bad++;
                $display("FAIL writeback_addr got=%h exp=%h", wb_addr_q[$], victim);
            end
            total++;
            if (wb_data_q[$] !== exp_blk) begin
                bad++;
                $display("FAIL writeback_data got=%h exp=%h", wb_data_q[$], exp_blk);
            end
        end
        total++;
        if (rd_q.size() != rd0 + (is_hit ? 0 : 1)) begin
            bad++;
            $display("FAIL refill_count addr=%h got=%0d exp=%0d", a, rd_q.size() - rd0, is_hit ? 0 : 1);
        end else if (!is_hit) begin
            total++;
            if (rd_q[$] !== {tg, idx}) begin
                bad++;
                $display("FAIL refill_addr got=%h exp=%h", rd_q[$], {tg, idx});
            end
        end

        if (is_hit) begin
            exp_hits++;
        end else begin
            exp_miss++;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_dirty[idx] = 1'b0;
        end
        if (wr) begin
            ref_w[a]     = wd;
            m_dirty[idx] = 1'b1;
        end

        total++;
`ifdef CACHE_PERF_CNT_EN
        if (hit_cnt !== 32'(exp_hits) || miss_cnt !== 32'(exp_miss)) begin
            bad++;
            $display("FAIL perf_counters got=%0d/%0d exp=%0d/%0d", hit_cnt, miss_cnt, exp_hits, exp_miss);
        end
`else
        if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            bad++;
            $display("FAIL perf_counters_off got=%0d/%0d exp=0/0", hit_cnt, miss_cnt);
        end
`endif
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            if (m_valid[i] && m_dirty[i]) begin
                logic [27:0]  b;
                logic [127:0] blk;
                logic [2:0]   ii;
                ii  = i[2:0];
                b   = {m_tag[i], ii};
                blk = bk_read(b);
                for (int w = 0; w < 4; w++) begin
                    logic [1:0] wo;
                    wo = w[1:0];
                    ref_w[{b, wo}] = blk[w*32 +: 32];
                end
            end
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
        end
        exp_hits = 0;
        exp_miss = 0;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = '0;
        proc_wdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (proc_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", proc_stall); end
        total++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
            bad++; $display("FAIL reset_mem_req got=%b%b exp=00", mem_read, mem_write);
        end
        total++;
        if (mem_addr !== 28'd0 || mem_wdata !== 128'd0) begin
            bad++; $display("FAIL reset_mem_bus got=%h/%h exp=0/0", mem_addr, mem_wdata);
        end
        total++;
        if (proc_rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", proc_rdata); end
        total++;
        if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            bad++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", hit_cnt, miss_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_plan_sequence();
        logic [127:0] wbd;
        lat = 3;
        access(1'b1, 1'b0, 30'h0000_0004, 32'h0);
        access(1'b1, 1'b0, 30'h0000_0004, 32'h0);
        access(1'b0, 1'b1, 30'h0000_0005, 32'hDEAD_BEEF);
        access(1'b1, 1'b0, 30'h0000_0005, 32'h0);
        access(1'b1, 1'b0, 30'h0000_0024, 32'h0);
        wbd = wb_data_q.size() > 0 ? wb_data_q[$] : 128'd0;
        total++;
        if (wbd[63:32] !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL victim_word1 got=%h exp=deadbeef", wbd[63:32]);
        end
    endtask

    task automatic test_reset_mid_miss();
        lat = 8;
        proc_read = 1'b1;
        proc_addr = 30'h0000_0004;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (mem_read !== 1'b1) begin bad++; $display("FAIL mid_miss_alloc got=%b exp=1", mem_read); end
        rst_n     = 1'b0;
        proc_read = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== 28'd0) begin
            bad++; $display("FAIL mid_miss_reset got=%b%b/%h exp=00/0", mem_read, mem_write, mem_addr);
        end
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        lat = 3;
        access(1'b1, 1'b0, 30'h0000_0004, 32'h0);
    endtask

    task automatic test_rw_both();
        logic [127:0] wbd;
        lat = 2;
        access(1'b1, 1'b1, 30'h0000_0004, 32'hCAFE_F00D);
        access(1'b1, 1'b0, {25'd5, 3'd1, 2'd0}, 32'h0);
        wbd = wb_data_q.size() > 0 ? wb_data_q[$] : 128'd0;
        total++;
        if (wbd[31:0] !== 32'hCAFE_F00D) begin
            bad++; $display("FAIL rw_both_dirty got=%h exp=cafef00d", wbd[31:0]);
        end
    endtask

    task automatic test_drop_request();
        logic [29:0] a;
        logic [2:0]  idx;
        logic        do_wb;
        logic        done;
        int          cyc;
        int          wb0;
        a   = {25'd20, 3'd2, 2'd1};
        idx = a[4:2];
        lat = 4;
        access(1'b0, 1'b1, {25'd9, 3'd2, 2'd3}, 32'h1357_9BDF);
        do_wb = m_valid[idx] && m_dirty[idx];
        wb0   = wb_addr_q.size();
        proc_read = 1'b1;
        proc_addr = a;
        @(negedge clk);
        proc_read = 1'b0;
        cyc  = 0;
        done = 1'b0;
        while (!done) begin
            #1;
            if (!mem_read && !mem_write) begin
                done = 1'b1;
            end else begin
                cyc++;
                if (cyc > 100) begin
                    total++; bad++;
                    $display("FAIL drop_timeout cycles=%0d", cyc);
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        total++;
        if (wb_addr_q.size() != wb0 + (do_wb ? 1 : 0)) begin
            bad++; $display("FAIL drop_writeback got=%0d exp=%0d", wb_addr_q.size() - wb0, do_wb ? 1 : 0);
        end
        total++;
        if (rd_q.size() == 0 || rd_q[$] !== a[29:2]) begin
            bad++; $display("FAIL drop_refill_addr got=%h exp=%h", rd_q.size() ? rd_q[$] : 28'h0, a[29:2]);
        end
        m_valid[idx] = 1'b1;
        m_tag[idx]   = a[29:5];
        m_dirty[idx] = 1'b0;
        exp_miss++;
        @(negedge clk);
        access(1'b1, 1'b0, a, 32'h0);
    endtask

    task automatic test_spurious_ready();
        spurious = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
            bad++; $display("FAIL spurious_ready got=%b%b exp=00", mem_read, mem_write);
        end
        @(negedge clk);
        access(1'b1, 1'b0, {25'd20, 3'd2, 2'd1}, 32'h0);
        access(1'b1, 1'b0, {25'd5, 3'd1, 2'd2}, 32'h0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            logic [29:0] a;
            logic [24:0] tg;
            logic [2:0]  idx;
            logic [1:0]  off;
            int          mode;
            tg   = 25'($urandom_range(0, 3));
            idx  = 3'($urandom_range(0, 7));
            off  = 2'($urandom_range(0, 3));
            a    = {tg, idx, off};
            mode = $urandom_range(0, 3);
            lat  = $urandom_range(1, 4);
            case (mode)
                0, 1:    access(1'b1, 1'b0, a, 32'h0);
                2:       access(1'b0, 1'b1, a, $urandom);
                default: access(1'b1, 1'b1, a, $urandom);
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_plan_sequence();
        test_reset_mid_miss();
        test_rw_both();
        test_drop_request();
        test_spurious_ready();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
